// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_sequencer: owns the fetch PC; advances on decode accept, handles  |
// | back-end redirects (one-cycle flush) and halt requests.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_out,
  input  logic        ready_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] pc_in,
  output logic        fetch_en,
  output logic        flush,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect_valid) begin
      // Masking keeps the whole target word live; low bits are always dropped.
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      state_d = S_FLUSH;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN, S_STALL: begin
          if (halt) begin
            state_d = S_HALT;
          end else if (valid_out && ready_out) begin
            pc_d    = pc_q + 32'd4;
            count_d = count_q + 32'd1;
            state_d = S_RUN;
          end else if (valid_out) begin
            state_d = S_STALL;
          end else begin
            state_d = S_RUN;
          end
        end
        S_FLUSH: state_d = halt ? S_HALT : S_RUN;
        S_HALT:  state_d = halt ? S_HALT : S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pc_in       = pc_q;
  assign fetch_count = count_q;
  assign fetch_en    = (state_q == S_RUN) || (state_q == S_STALL);
  assign flush       = (state_q == S_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_sequencer: directed scenarios plus random traffic, checked     |
// | against a cycle-level behavioural model.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_out = 1'b0;
  logic        ready_out = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic [31:0] pc_in;
  logic        fetch_en;
  logic        flush;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: observable mode is "idle / flushing / halted / fetching".
  logic [31:0] m_pc = C_RESET_PC;
  logic [31:0] m_cnt = 32'd0;
  bit          m_idle = 1'b1;
  bit          m_flush = 1'b0;
  bit          m_halted = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(C_RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_out      (valid_out),
    .ready_out      (ready_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .pc_in          (pc_in),
    .fetch_en       (fetch_en),
    .flush          (flush),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_fetching();
    return !m_idle && !m_flush && !m_halted;
  endfunction

  // Applies the behavioural rules for one rising edge using the current inputs.
  task automatic model_edge();
    bit fetching;
    fetching = model_fetching();
    if (reset) begin
      m_pc = C_RESET_PC; m_cnt = 0; m_idle = 1; m_flush = 0; m_halted = 0;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_idle = 0; m_flush = 1; m_halted = 0;
    end else if (m_idle) begin
      m_idle = 0;
    end else if (m_flush) begin
      m_flush = 0; m_halted = halt;
    end else if (m_halted) begin
      m_halted = halt;
    end else if (fetching) begin
      if (halt) m_halted = 1;
      else if (valid_out && ready_out) begin
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit rd, input bit rv,
                      input logic [31:0] rpc, input bit h);
    reset = r; valid_out = v; ready_out = rd;
    redirect_valid = rv; redirect_pc = rpc; halt = h;
    @(posedge clk);
    model_edge();
    #1;
    check("pc_in", pc_in, m_pc);
    check("fetch_count", fetch_count, m_cnt);
    check("fetch_en", {31'd0, fetch_en}, {31'd0, model_fetching()});
    check("flush", {31'd0, flush}, {31'd0, m_flush});
  endtask

  initial begin
    // Reset held three cycles, then stream accepts.
    repeat (3) step(1, 1, 1, 0, 0, 0);
    check("reset_pc", pc_in, 32'h100);
    check("reset_fetch_en", {31'd0, fetch_en}, 32'd0);
    repeat (5) step(0, 1, 1, 0, 0, 0);
    check("startup_cnt", fetch_count, 32'd4);
    check("startup_pc", pc_in, 32'h110);

    // Back-pressure at 0x200.
    step(0, 1, 1, 1, 32'h200, 0);
    step(0, 1, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    check("stall_pc", pc_in, 32'h200);
    step(0, 1, 1, 0, 0, 0);
    check("stall_release_pc", pc_in, 32'h204);

    // Redirect colliding with an accept.
    step(0, 0, 0, 1, 32'h300, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 32'h1003, 0);
    check("collide_pc", pc_in, 32'h1000);
    check("collide_flush", {31'd0, flush}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    check("collide_fetch_en", {31'd0, fetch_en}, 32'd1);

    // Halt while streaming at 0x400.
    step(0, 1, 1, 1, 32'h400, 0);
    step(0, 1, 1, 0, 0, 1);
    repeat (4) step(0, 1, 1, 0, 0, 1);
    check("halt_pc", pc_in, 32'h400);
    step(0, 1, 1, 0, 0, 0);
    check("resume_fetch_en", {31'd0, fetch_en}, 32'd1);
    step(0, 1, 1, 0, 0, 0);
    check("resume_pc", pc_in, 32'h404);

    // Redirect during halt, then PC wrap.
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 32'hFFFF_FFFE, 1);
    step(0, 1, 1, 0, 0, 1);
    check("halt_after_flush", {31'd0, fetch_en}, 32'd0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check("wrap_pc", pc_in, 32'h0);

    // Reset in the flush cycle.
    step(0, 1, 1, 1, 32'h8000, 0);
    step(1, 1, 1, 1, 32'h9000, 0);
    check("reset_mid_flush_pc", pc_in, 32'h100);
    step(0, 1, 1, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 10,
           tgt, $urandom_range(0, 99) < 15);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
